// File: rtl/trace_pkg.sv
// Shared types and helpers for the retirement-trace byte stream.
package trace_pkg;

    localparam int unsigned RECORD_BYTES = 10;
    localparam int unsigned IDX_W        = 4;

    typedef struct packed {
        logic        exc;
        logic [3:0]  code;
        logic [31:0] pc;
        logic [31:0] instr;
    } trace_rec_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    // Flag byte: exception bit on top, code only meaningful when exc is set.
    function automatic logic [7:0] pack_flags(input logic exc, input logic [3:0] code);
        return {exc, 3'b000, (exc ? code : 4'h0)};
    endfunction

    // Byte idx of a frame; pc and instr are sent little-endian.
    function automatic logic [7:0] frame_byte(input trace_rec_t rec,
                                              input logic [IDX_W-1:0] idx,
                                              input logic [7:0] sync);
        logic [7:0] b;
        case (idx)
            4'd0:    b = sync;
            4'd1:    b = pack_flags(rec.exc, rec.code);
            4'd2:    b = rec.pc[7:0];
            4'd3:    b = rec.pc[15:8];
            4'd4:    b = rec.pc[23:16];
            4'd5:    b = rec.pc[31:24];
            4'd6:    b = rec.instr[7:0];
            4'd7:    b = rec.instr[15:8];
            4'd8:    b = rec.instr[23:16];
            4'd9:    b = rec.instr[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO; pointers carry one wrap bit to separate full from empty.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  trace_rec_t               wdata,
    output trace_rec_t               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic        push_ok, pop_ok;
    trace_rec_t  mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign level = level_q;

    // Pointer and level update; requests that cannot be honoured are ignored.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? LW'(wr_ptr_q + LW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? LW'(rd_ptr_q + LW'(1)) : rd_ptr_q;
        level_d  = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = LW'(level_q + LW'(1));
            2'b01:   level_d = LW'(level_q - LW'(1));
            default: level_d = level_q;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/trace_stream_tx.sv
// Retirement-trace transmitter: capture, drop counting and 10-byte frame serializer.
module trace_stream_tx
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     trace_valid,
    input  logic [31:0]              trace_pc,
    input  logic [31:0]              trace_instr,
    input  logic                     trace_exc,
    input  logic [3:0]               trace_exc_code,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              drop_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECORD_BYTES - 1);

    tx_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    trace_rec_t        frame_q, frame_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [15:0]       drop_count_q, drop_count_d;

    trace_rec_t        rec_in, fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic              push, drop, pop;
    logic              accept, last, load;

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (rec_in),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign drop_count = drop_count_q;

    // Capture: full is judged on the registered level, so a pop never frees a slot the same edge.
    always_comb begin
        rec_in       = '{exc: trace_exc, code: trace_exc_code, pc: trace_pc, instr: trace_instr};
        push         = trace_valid && !fifo_full;
        drop         = trace_valid && fifo_full;
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            frame_q      <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            drop_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Next state: leave SEND only once the last byte is taken and nothing is queued.
    always_comb begin
        accept  = (state_q == ST_SEND) && tx_ready;
        last    = (idx_q == LAST_IDX);
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty)                    state_d = ST_SEND;
            ST_SEND: if (accept && last && fifo_empty)   state_d = ST_IDLE;
            default:                                     state_d = ST_IDLE;
        endcase
    end

    // Outputs: load a new frame (from IDLE or straight after byte 9) or advance on accept.
    always_comb begin
        pop        = 1'b0;
        frame_d    = frame_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        load       = !fifo_empty && ((state_q == ST_IDLE) || (accept && last));
        if (load) begin
            pop       = 1'b1;
            frame_d   = fifo_rdata;
            idx_d     = '0;
            tx_data_d = SYNC_BYTE;
        end else if (accept) begin
            if (last) begin
                idx_d     = '0;
                tx_data_d = 8'h00;
            end else begin
                idx_d     = IDX_W'(idx_q + IDX_W'(1));
                tx_data_d = frame_byte(frame_q, IDX_W'(idx_q + IDX_W'(1)), SYNC_BYTE);
            end
        end
        tx_valid_d = (state_d == ST_SEND);
    end

endmodule
